// File: rtl/acia_bridge_pkg.sv
// Shared types and constants for the W65C51N register-port bridge.
// Covers the FSM states, the register-select codes and the status bit positions.
package acia_bridge_pkg;

    typedef enum logic [2:0] {
        INIT_CMD,
        INIT_CTL,
        RD_STAT,
        EVAL,
        RD_DATA,
        CAPTURE,
        WR_DATA
    } state_e;

    localparam logic [1:0] RS_DATA = 2'b00;
    localparam logic [1:0] RS_STAT = 2'b01;
    localparam logic [1:0] RS_CMD  = 2'b10;
    localparam logic [1:0] RS_CTRL = 2'b11;

    localparam int ST_PE   = 0;
    localparam int ST_FE   = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_RDRF = 3;
    localparam int ST_TDRE = 4;

    typedef struct packed {
        logic       cs;
        logic       rw;
        logic [1:0] rs;
        logic [7:0] din;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs: 1'b0, rw: 1'b1, rs: RS_DATA, din: 8'h00};

    function automatic bus_t bus_write(input logic [1:0] rs, input logic [7:0] din);
        return '{cs: 1'b1, rw: 1'b0, rs: rs, din: din};
    endfunction

    function automatic bus_t bus_read(input logic [1:0] rs);
        return '{cs: 1'b1, rw: 1'b1, rs: rs, din: 8'h00};
    endfunction

endpackage

// File: rtl/acia_bus_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head is valid whenever empty_o is low.
// An extra pointer bit tells full from empty when the index bits match.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are discarded by clearing the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/acia_bus_bridge.sv
// Autonomous master for a W65C51N-style UART port: programs CMD/CTRL after reset,
// then polls status, draining RX bytes into one FIFO and feeding TX bytes from another.
//
// state    | meaning
// INIT_CMD | write CMD_INIT to the command register
// INIT_CTL | write CTRL_INIT to the control register
// RD_STAT  | read strobe on the status register
// EVAL     | decode returned status, pick next action
// RD_DATA  | read strobe on the receive data register
// CAPTURE  | push returned byte into the RX FIFO
// WR_DATA  | write TX FIFO head to the transmit register, pop it
module acia_bus_bridge
    import acia_bridge_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] CMD_INIT   = 8'h00,
    parameter logic [7:0] CTRL_INIT  = 8'h1E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       err_overrun_o,
    output logic       err_framing_o,
    input  logic       err_clr_i,
    output logic       ua_cs_o,
    output logic       ua_rw_o,
    output logic       ua_rs1_o,
    output logic       ua_rs0_o,
    output logic [7:0] ua_din_o,
    input  logic [7:0] ua_dout_i
);

    state_e     state_q, state_d;
    bus_t       bus_q, bus_d;
    logic       run_q;
    logic       err_ovr_q, err_ovr_d;
    logic       err_fe_q, err_fe_d;

    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_empty, rx_push;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_valid_i),
        .din_i   (tx_data_i),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .din_i   (ua_dout_i),
        .pop_i   (rx_ready_i),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_data_o)
    );

    assign tx_ready_o = !tx_full;
    assign rx_valid_o = !rx_empty;

    always_comb begin
        state_d   = state_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        err_ovr_d = err_clr_i ? 1'b0 : err_ovr_q;
        err_fe_d  = err_clr_i ? 1'b0 : err_fe_q;

        // The cycle that leaves reset re-enters INIT_CMD so its strobe is the first one seen.
        if (!run_q) begin
            state_d = INIT_CMD;
        end else begin
            unique case (state_q)
                INIT_CMD: state_d = INIT_CTL;
                INIT_CTL: state_d = RD_STAT;
                RD_STAT:  state_d = EVAL;
                EVAL: begin
                    if (ua_dout_i[ST_OVR]) err_ovr_d = 1'b1;
                    if (ua_dout_i[ST_FE])  err_fe_d  = 1'b1;
                    if (ua_dout_i[ST_RDRF] && !rx_full)
                        state_d = RD_DATA;
                    else if (ua_dout_i[ST_TDRE] && !tx_empty)
                        state_d = WR_DATA;
                    else
                        state_d = RD_STAT;
                end
                RD_DATA:  state_d = CAPTURE;
                CAPTURE: begin
                    rx_push = 1'b1;
                    state_d = RD_STAT;
                end
                WR_DATA: begin
                    tx_pop  = 1'b1;
                    state_d = RD_STAT;
                end
                default:  state_d = INIT_CMD;
            endcase
        end
    end

    // Bus fields are registered from the next state so they line up with state_q.
    always_comb begin
        bus_d = BUS_IDLE;
        unique case (state_d)
            INIT_CMD: bus_d = bus_write(RS_CMD, CMD_INIT);
            INIT_CTL: bus_d = bus_write(RS_CTRL, CTRL_INIT);
            RD_STAT:  bus_d = bus_read(RS_STAT);
            RD_DATA:  bus_d = bus_read(RS_DATA);
            WR_DATA:  bus_d = bus_write(RS_DATA, tx_head);
            default:  bus_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT_CMD;
            bus_q     <= BUS_IDLE;
            run_q     <= 1'b0;
            err_ovr_q <= 1'b0;
            err_fe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            run_q     <= 1'b1;
            err_ovr_q <= err_ovr_d;
            err_fe_q  <= err_fe_d;
        end
    end

    assign ua_cs_o       = bus_q.cs;
    assign ua_rw_o       = bus_q.rw;
    assign ua_rs1_o      = bus_q.rs[1];
    assign ua_rs0_o      = bus_q.rs[0];
    assign ua_din_o      = bus_q.din;
    assign err_overrun_o = err_ovr_q;
    assign err_framing_o = err_fe_q;

endmodule
